marker_overlay_gen: RTL
=======================

Name: marker_overlay_gen

Overview:
- Parametrised second-generation overlay stage between the centroid/object-detect stage and the video output path.
- Counts raster position over an RGB pixel stream and repaints pixels in one of three marker shapes (full crosshair, short cross, box outline) centred on the tracked centroid.
- Centroid and mode are latched once per frame, so the marker is stable within a frame.
- Persists the marker for a configurable number of frames after the object is lost ("coast"), drawn in a distinct colour, and flags malformed frames.

Parameters:
- PIXEL_W, 12, pixel data width (RGB444 default).
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- X_W, 10, centroid/x-counter width; must satisfy 2^X_W >= IMG_WIDTH.
- Y_W, 9, centroid/y-counter width; must satisfy 2^Y_W >= IMG_HEIGHT.
- MARK_SIZE, 8, half-extent S of short cross and box, in pixels.
- MARK_THICK, 1, half-thickness T of drawn lines; constraint T < S.
- TRACK_COLOR, 12'h0F0, colour for a live object.
- COAST_COLOR, 12'hFF0, colour while coasting.
- PERSIST_FRAMES, 3, number of frames drawn after the object is lost (0 disables coasting).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_data_valid  in  1  input pixel strobe.
- i_data  in  PIXEL_W  input pixel.
- i_end_frame  in  1  one-cycle pulse marking the last cycle of a frame.
- i_centroid_x  in  X_W  object centroid column.
- i_centroid_y  in  Y_W  object centroid row.
- i_obj_valid  in  1  centroid valid for the next frame.
- i_mode  in  2  0 = pass-through, 1 = full crosshair, 2 = short cross, 3 = box outline.
- o_data_valid  out  1  output pixel strobe.
- o_data  out  PIXEL_W  output pixel.
- o_track_state  out  2  0 = OFF, 1 = TRACK, 2 = COAST.
- o_frame_err  out  1  one-cycle pulse: previous frame pixel count was not IMG_WIDTH*IMG_HEIGHT.

Behaviour:

Reset (asynchronous, i_rstn=0):
- o_data=0, o_data_valid=0, o_frame_err=0.
- State OFF; x/y/pixel counters=0; shadow centroid=0; shadow mode=0; persist count=0.

Latency and datapath:
- Fixed 1 cycle, no backpressure: o_data_valid(t+1)=i_data_valid(t).
- o_data(t+1) = marker colour if the pixel is drawn, else i_data(t).
- When i_data_valid=0, o_data holds its last value.

Position counters:
- Advance on each i_data_valid; x wraps at IMG_WIDTH-1 and increments y.
- y wraps from IMG_HEIGHT-1 to 0 (overlong frame).
- Pixel counter saturates at IMG_WIDTH*IMG_HEIGHT+1.

Draw rules (dx=|x-cx|, dy=|y-cy| on shadow values, computed without underflow):
- mode 1: dx<=T or dy<=T.
- mode 2: (dx<=T and dy<=S) or (dy<=T and dx<=S).
- mode 3: max(dx,dy) in [S-T, S].
- mode 0, or state OFF: never drawn.
- Colour: TRACK_COLOR in TRACK, COAST_COLOR in COAST.

Frame boundary (i_end_frame=1 cycle):
- A pixel valid in the same cycle is processed as the frame's last pixel, using the old shadows.
- At the clock edge: x, y and pixel counters clear; shadow mode <= i_mode.
- o_frame_err pulses the next cycle if the pixel count including that cycle's pixel != IMG_WIDTH*IMG_HEIGHT.

State machine (transitions only at i_end_frame):
- Any state with i_obj_valid=1: go to TRACK; shadow centroid <= inputs; persist <= PERSIST_FRAMES.
- TRACK with i_obj_valid=0: go to COAST if PERSIST_FRAMES>0, else OFF. Shadow centroid held.
- COAST with i_obj_valid=0: persist decrements; go to OFF when it was already 1 (i.e. exactly PERSIST_FRAMES coast frames are drawn).
- OFF with i_obj_valid=0: stay OFF.
- o_track_state is the registered state.
- The first frame after reset is always drawn as OFF.

Boundary conditions:
- i_centroid_x/y changes mid-frame: ignored until the next i_end_frame.
- Centroid at the image edge (e.g. 0 or IMG_WIDTH-1): the marker clips naturally; no wrap artefacts.
- Reset mid-frame: all state returns to reset values immediately; the next frame starts at (0,0).
- i_end_frame with zero pixels: o_frame_err=1.

Test Plan:
1. Reset; frame 1 (640x480 pixels 12'h123, obj_valid=1, cx=100, cy=50, mode=1) -> all output 12'h123, state OFF. Frame 2 -> row 50 rows 49–51 and columns 99–101 = 12'h0F0, others 12'h123, o_track_state=1, o_frame_err never pulses.
2. Mode 2 with S=8, T=1, centroid (320,240) -> pixel (328,240) green, (329,240) unchanged, (320,232) green, (330,250) unchanged.
3. Mode 3, centroid (320,240) -> (312,240) and (328,248) green; (320,240) and (311,240) unchanged.
4. TRACK, then obj_valid=0 for 5 frames, PERSIST_FRAMES=3 -> 3 frames drawn with 12'hFF0 at the last centroid (state 2), then OFF, unchanged pixels.
5. Frame of 640*480-1 pixels then i_end_frame -> o_frame_err=1 for exactly 1 cycle; next frame still starts at (0,0).
6. Assert i_rstn=0 at pixel 1000 of a frame -> o_data_valid=0, o_data=0 immediately; after release, state OFF and the first pixel maps to (0,0).

Source files
------------

// File: rtl/marker_overlay_gen_if.sv
`timescale 1ns/1ps
// Pixel stream, centroid/mode control and status bundle for marker_overlay_gen.
interface marker_overlay_gen_if #(
    parameter int PIXEL_W = 12,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
);
    logic               i_data_valid;
    logic [PIXEL_W-1:0] i_data;
    logic               i_end_frame;
    logic [X_W-1:0]     i_centroid_x;
    logic [Y_W-1:0]     i_centroid_y;
    logic               i_obj_valid;
    logic [1:0]         i_mode;
    logic               o_data_valid;
    logic [PIXEL_W-1:0] o_data;
    logic [1:0]         o_track_state;
    logic               o_frame_err;

    modport master (
        output i_data_valid, i_data, i_end_frame, i_centroid_x, i_centroid_y, i_obj_valid, i_mode,
        input  o_data_valid, o_data, o_track_state, o_frame_err
    );

    modport slave (
        input  i_data_valid, i_data, i_end_frame, i_centroid_x, i_centroid_y, i_obj_valid, i_mode,
        output o_data_valid, o_data, o_track_state, o_frame_err
    );
endinterface

// File: rtl/marker_overlay_gen.sv
`timescale 1ns/1ps
// Raster-position marker overlay: repaints crosshair / short cross / box pixels around
// a per-frame latched centroid, with post-loss coasting and frame-size error flagging.
module marker_overlay_gen #(
    parameter int                  PIXEL_W        = 12,
    parameter int                  IMG_WIDTH      = 640,
    parameter int                  IMG_HEIGHT     = 480,
    parameter int                  X_W            = 10,
    parameter int                  Y_W            = 9,
    parameter int                  MARK_SIZE      = 8,
    parameter int                  MARK_THICK     = 1,
    parameter logic [PIXEL_W-1:0]  TRACK_COLOR    = 12'h0F0,
    parameter logic [PIXEL_W-1:0]  COAST_COLOR    = 12'hFF0,
    parameter int                  PERSIST_FRAMES = 3
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    marker_overlay_gen_if.slave bus
);

    typedef enum logic [1:0] {ST_OFF = 2'd0, ST_TRACK = 2'd1, ST_COAST = 2'd2} state_t;

    localparam int D_W  = (X_W > Y_W) ? X_W : Y_W;
    localparam int PC_W = $clog2(IMG_WIDTH * IMG_HEIGHT + 2);
    localparam int PS_W = (PERSIST_FRAMES > 0) ? $clog2(PERSIST_FRAMES + 1) : 1;

    localparam logic [X_W-1:0]  X_LAST     = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]  Y_LAST     = Y_W'(IMG_HEIGHT - 1);
    localparam logic [PC_W-1:0] PIX_TOTAL  = PC_W'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [PC_W-1:0] PIX_SAT    = PC_W'(IMG_WIDTH * IMG_HEIGHT + 1);
    localparam logic [D_W-1:0]  S_D        = D_W'(MARK_SIZE);
    localparam logic [D_W-1:0]  T_D        = D_W'(MARK_THICK);
    localparam logic [D_W-1:0]  IN_D       = D_W'(MARK_SIZE - MARK_THICK);
    localparam logic [PS_W-1:0] PERSIST_LD = PS_W'(PERSIST_FRAMES);

    function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] c);
        return (c == PIX_SAT) ? c : c + 1'b1;
    endfunction

    function automatic logic [D_W-1:0] abs_diff(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    state_t             state_q, state_d;
    logic [PS_W-1:0]    persist_q, persist_d;
    logic [X_W-1:0]     x_cnt, cx_sh;
    logic [Y_W-1:0]     y_cnt, cy_sh;
    logic [1:0]         mode_sh;
    logic [PC_W-1:0]    pix_cnt, pix_incl;
    logic               draw_en, hit_p0;
    logic [PIXEL_W-1:0] mark_color;
    logic [D_W-1:0]     dx, dy, dmax;
    logic               vld_p1, frame_err_p1;
    logic [PIXEL_W-1:0] data_p1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_OFF;
            persist_q <= '0;
        end else begin
            state_q   <= state_d;
            persist_q <= persist_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        persist_d = persist_q;
        if (bus.i_end_frame) begin
            if (bus.i_obj_valid) begin
                state_d   = ST_TRACK;
                persist_d = PERSIST_LD;
            end else begin
                case (state_q)
                    ST_TRACK: state_d = (PERSIST_FRAMES > 0) ? ST_COAST : ST_OFF;
                    ST_COAST: begin
                        if (persist_q <= PS_W'(1)) begin
                            state_d   = ST_OFF;
                            persist_d = '0;
                        end else begin
                            persist_d = persist_q - 1'b1;
                        end
                    end
                    default:  state_d = ST_OFF;
                endcase
            end
        end
    end

    always_comb begin
        draw_en    = 1'b0;
        mark_color = TRACK_COLOR;
        case (state_q)
            ST_TRACK: draw_en = (mode_sh != 2'd0);
            ST_COAST: begin
                draw_en    = (mode_sh != 2'd0);
                mark_color = COAST_COLOR;
            end
            default: ;
        endcase
    end

    // Stage p0: raster position against the latched centroid
    always_comb begin
        dx   = abs_diff(D_W'(x_cnt), D_W'(cx_sh));
        dy   = abs_diff(D_W'(y_cnt), D_W'(cy_sh));
        dmax = (dx > dy) ? dx : dy;
        case (mode_sh)
            2'd1:    hit_p0 = (dx <= T_D) || (dy <= T_D);
            2'd2:    hit_p0 = ((dx <= T_D) && (dy <= S_D)) || ((dy <= T_D) && (dx <= S_D));
            2'd3:    hit_p0 = (dmax >= IN_D) && (dmax <= S_D);
            default: hit_p0 = 1'b0;
        endcase
    end

    assign pix_incl = bus.i_data_valid ? sat_inc(pix_cnt) : pix_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            pix_cnt <= '0;
            cx_sh   <= '0;
            cy_sh   <= '0;
            mode_sh <= '0;
        end else if (bus.i_end_frame) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            pix_cnt <= '0;
            mode_sh <= bus.i_mode;
            if (bus.i_obj_valid) begin
                cx_sh <= bus.i_centroid_x;
                cy_sh <= bus.i_centroid_y;
            end
        end else if (bus.i_data_valid) begin
            pix_cnt <= pix_incl;
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // Stage p1: registered output pixel and frame status
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_p1       <= 1'b0;
            data_p1      <= '0;
            frame_err_p1 <= 1'b0;
        end else begin
            vld_p1       <= bus.i_data_valid;
            frame_err_p1 <= bus.i_end_frame && (pix_incl != PIX_TOTAL);
            if (bus.i_data_valid)
                data_p1 <= (draw_en && hit_p0) ? mark_color : bus.i_data;
        end
    end

    assign bus.o_data_valid  = vld_p1;
    assign bus.o_data        = data_p1;
    assign bus.o_frame_err   = frame_err_p1;
    assign bus.o_track_state = state_q;

endmodule
